button_debouncer: RTL

BUTTON_DEBOUNCER -- requirements
Module: button_debouncer

---
 rtl/button_debouncer_pkg.sv | 14 +
 rtl/button_debouncer_sync_2ff.sv | 27 ++
 rtl/button_debouncer.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/button_debouncer_pkg.sv
// Shared state encoding and counter widths for the button debouncer.
package button_debouncer_pkg;

  localparam int DB_CNT_W   = 16;
  localparam int HOLD_CNT_W = 24;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_PRESS_DB   = 2'd1,
    ST_HELD       = 2'd2,
    ST_RELEASE_DB = 2'd3
  } state_t;

endpackage

// File: rtl/button_debouncer_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input bit.
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // Two-stage capture; both stages park at RST_VAL while reset is low.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/button_debouncer.sv
// Button debouncer: synchronizes the pad, debounces press and release,
// and reports press/release/long-press strobes plus a 3-bit press count.
module button_debouncer
  import button_debouncer_pkg::*;
#(
  parameter logic [DB_CNT_W-1:0]   DEBOUNCE_CYCLES   = 16'd50000,
  parameter logic [HOLD_CNT_W-1:0] LONG_PRESS_CYCLES = 24'd12000000,
  parameter logic                  ACTIVE_LOW        = 1'b1
) (
  input  logic       WB_CLK,
  input  logic       WB_RST_N,
  input  logic       btn_raw,
  output logic       btn_level,
  output logic       press_pulse,
  output logic       release_pulse,
  output logic       long_pulse,
  output logic [2:0] press_count
);

  localparam int DBW1 = DB_CNT_W + 1;

  logic pad_sync;
  logic pressed;

  // In reset the synchronizer holds the idle (unpressed) pad level.
  sync_2ff #(
    .RST_VAL (ACTIVE_LOW)
  ) u_sync (
    .clk_i  (WB_CLK),
    .rst_ni (WB_RST_N),
    .d_i    (btn_raw),
    .q_o    (pad_sync)
  );

  assign pressed = ACTIVE_LOW ? ~pad_sync : pad_sync;

  state_t                state_q,  state_d;
  logic [DB_CNT_W-1:0]   db_cnt_q, db_cnt_d;
  logic [HOLD_CNT_W-1:0] hold_q,   hold_d;
  logic                  press_q,  press_d;
  logic                  rel_q,    rel_d;
  logic                  long_q,   long_d;
  logic [2:0]            cnt_q,    cnt_d;
  logic                  db_done;

  // The sample that moved the FSM into a debounce state is the first of the
  // run, so the counter only has to cover the remaining samples. A debounce
  // state always lasts at least one cycle.
  assign db_done = ({1'b0, db_cnt_q} + DBW1'(2)) >= {1'b0, DEBOUNCE_CYCLES};

  // Next-state, counter and strobe logic.
  always_comb begin
    state_d  = state_q;
    db_cnt_d = db_cnt_q;
    hold_d   = hold_q;
    press_d  = 1'b0;
    rel_d    = 1'b0;
    long_d   = 1'b0;
    cnt_d    = cnt_q;

    // Hold time advances in HELD and RELEASE_DB and saturates at the
    // long-press threshold, so the long strobe can only fire once per press.
    if ((state_q == ST_HELD) || (state_q == ST_RELEASE_DB)) begin
      if (hold_q != LONG_PRESS_CYCLES) begin
        hold_d = hold_q + HOLD_CNT_W'(1);
        long_d = ((hold_q + HOLD_CNT_W'(1)) == LONG_PRESS_CYCLES);
      end
    end

    case (state_q)
      ST_IDLE: begin
        db_cnt_d = '0;
        hold_d   = '0;
        if (pressed) state_d = ST_PRESS_DB;
      end
      ST_PRESS_DB: begin
        if (!pressed) begin
          state_d  = ST_IDLE;
          db_cnt_d = '0;
        end else if (db_done) begin
          state_d  = ST_HELD;
          db_cnt_d = '0;
          hold_d   = '0;
          press_d  = 1'b1;
          cnt_d    = cnt_q + 3'd1;
        end else begin
          db_cnt_d = db_cnt_q + DB_CNT_W'(1);
        end
      end
      ST_HELD: begin
        if (!pressed) begin
          state_d  = ST_RELEASE_DB;
          db_cnt_d = '0;
        end
      end
      ST_RELEASE_DB: begin
        if (pressed) begin
          state_d  = ST_HELD;
          db_cnt_d = '0;
        end else if (db_done) begin
          state_d  = ST_IDLE;
          db_cnt_d = '0;
          hold_d   = '0;
          rel_d    = 1'b1;
        end else begin
          db_cnt_d = db_cnt_q + DB_CNT_W'(1);
        end
      end
      default: begin
        state_d  = ST_IDLE;
        db_cnt_d = '0;
        hold_d   = '0;
      end
    endcase
  end

  // State, counters and registered strobes; reset clears everything.
  always_ff @(posedge WB_CLK or negedge WB_RST_N) begin
    if (!WB_RST_N) begin
      state_q  <= ST_IDLE;
      db_cnt_q <= '0;
      hold_q   <= '0;
      press_q  <= 1'b0;
      rel_q    <= 1'b0;
      long_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      db_cnt_q <= db_cnt_d;
      hold_q   <= hold_d;
      press_q  <= press_d;
      rel_q    <= rel_d;
      long_q   <= long_d;
      cnt_q    <= cnt_d;
    end
  end

  assign btn_level     = (state_q == ST_HELD) || (state_q == ST_RELEASE_DB);
  assign press_pulse   = press_q;
  assign release_pulse = rel_q;
  assign long_pulse    = long_q;
  assign press_count   = cnt_q;

endmodule
